// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory-access stage: data-bus handshake, lane alignment, load extension
module mem_stage #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 reg_write,
    input  logic [WORD_SIZE-1:0] result,
    input  logic [WORD_SIZE-1:0] save_data,
    input  logic [REG_SEL-1:0]   rd,
    input  logic [1:0]           data_size,
    input  logic                 data_sign,
    output logic                 stall,
    output logic [WORD_SIZE-1:0] mem_forward,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    output logic [WORD_SIZE-1:0] dmem_wdata,
    output logic [3:0]           dmem_be,
    input  logic                 dmem_ready,
    input  logic                 dmem_rvalid,
    input  logic [WORD_SIZE-1:0] dmem_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_SEL-1:0]   wb_rd,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic                 misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] h_result;
    logic [WORD_SIZE-1:0] h_save;
    logic [REG_SEL-1:0]   h_rd;
    logic [1:0]           h_size;
    logic                 h_sign;
    logic                 h_read;
    logic                 h_write;
    logic                 h_reg_write;

    logic                 in_mem;
    logic                 in_illegal;
    logic [1:0]           lane;
    logic [3:0]           be_raw;
    logic [WORD_SIZE-1:0] wdata_raw;
    logic [WORD_SIZE-1:0] shifted;
    logic [WORD_SIZE-1:0] load_val;

    assign in_mem     = mem_read | mem_write;
    assign in_illegal = (data_size == 2'b11)
                      | ((data_size == 2'b01) & result[0])
                      | ((data_size == 2'b10) & (result[1:0] != 2'b00));

    assign lane        = h_result[1:0];
    assign stall       = (state != IDLE);
    assign mem_forward = h_result;

    always_comb begin
        be_raw    = 4'b1111;
        wdata_raw = h_save;
        case (h_size)
            2'b00: begin
                be_raw    = 4'b0001 << lane;
                wdata_raw = {4{h_save[7:0]}};
            end
            2'b01: begin
                be_raw    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_raw = {2{h_save[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_raw = h_save;
            end
        endcase
    end

    // Bus outputs are gated by REQ so they read zero whenever no access is offered.
    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req & h_write & ~h_read;
    assign dmem_addr  = dmem_req ? {h_result[ADDR_SIZE-1:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? be_raw : 4'b0000;
    assign dmem_wdata = dmem_req ? wdata_raw : '0;

    assign shifted = dmem_rdata >> {lane, 3'b000};

    always_comb begin
        load_val = shifted;
        case (h_size)
            2'b00:   load_val = {{(WORD_SIZE-8){h_sign & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{(WORD_SIZE-16){h_sign & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            h_result     <= '0;
            h_save       <= '0;
            h_rd         <= '0;
            h_size       <= 2'b00;
            h_sign       <= 1'b0;
            h_read       <= 1'b0;
            h_write      <= 1'b0;
            h_reg_write  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misaligned   <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            misaligned   <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        h_result    <= result;
                        h_save      <= save_data;
                        h_rd        <= rd;
                        h_size      <= data_size;
                        h_sign      <= data_sign;
                        h_read      <= mem_read;
                        h_write     <= mem_write;
                        h_reg_write <= reg_write;
                        if (!in_mem) begin
                            wb_valid     <= 1'b1;
                            wb_reg_write <= reg_write;
                            wb_rd        <= rd;
                            wb_data      <= result;
                        end else if (in_illegal) begin
                            wb_valid   <= 1'b1;
                            misaligned <= 1'b1;
                            wb_rd      <= rd;
                            wb_data    <= result;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        // A read+write instruction is a load, so h_read decides the path.
                        if (h_read) begin
                            state <= WAIT;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_rd    <= h_rd;
                            state    <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= h_reg_write;
                        wb_rd        <= h_rd;
                        wb_data      <= load_val;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with random and directed traffic
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
    logic [31:0] result = '0, save_data = '0;
    logic [4:0]  rd = '0;
    logic [1:0]  data_size = 2'b00;
    logic        data_sign = 1'b0;
    logic        stall;
    logic [31:0] mem_forward;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .result(result),
        .save_data(save_data), .rd(rd), .data_size(data_size), .data_sign(data_sign),
        .stall(stall), .mem_forward(mem_forward), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_data(wb_data), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] fwd;
        logic        mis;
        logic        chk;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
        logic        load;
        int          rdy_d;
        int          rv_d;
    } bus_t;

    wb_t  wbq[$];
    bus_t busq[$];
    int   n_chk = 0, n_fail = 0, stall_hi = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ext_load(input logic [31:0] rdat, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sg);
        int          ai = int'(a);
        logic [7:0]  b = rdat[8*ai +: 8];
        logic [15:0] h;
        h = (ai <= 2) ? rdat[8*ai +: 16] : 16'h0;
        if (sz == 2'b00) return sg ? 32'($signed(b)) : {24'h0, b};
        if (sz == 2'b01) return sg ? 32'($signed(h)) : {16'h0, h};
        return rdat;
    endfunction

    task automatic issue(input logic rop, input logic wop, input logic rw, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] r, input logic [1:0] sz,
                         input logic sg, input logic [31:0] rdat, input int rdy_d, input int rv_d);
        int   w = 0;
        wb_t  e;
        bus_t b;
        logic bad;
        @(negedge clk);
        while (stall && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (stall) begin
            check("issue_wait", stall, 1'b0);
            return;
        end
        mem_read = rop; mem_write = wop; reg_write = rw; result = res; save_data = sd;
        rd = r; data_size = sz; data_sign = sg; in_valid = 1'b1;
        bad = (sz == 2'b11) || (sz == 2'b01 && res[0]) || (sz == 2'b10 && res[1:0] != 2'b00);
        e.rd = r; e.fwd = res; e.data = res; e.mis = 1'b0; e.chk = 1'b1; e.rw = rw;
        if (rop || wop) begin
            if (bad) begin
                e.rw = 1'b0; e.mis = 1'b1; e.chk = 1'b0;
            end else begin
                b.addr = res & 32'hFFFF_FFFC;
                b.we = wop && !rop; b.load = rop;
                b.rdy_d = rdy_d; b.rv_d = rv_d; b.rdata = rdat;
                case (sz)
                    2'b00:   begin b.be = 4'b0001 << res[1:0]; b.wdata = {4{sd[7:0]}}; end
                    2'b01:   begin b.be = res[1] ? 4'b1100 : 4'b0011; b.wdata = {2{sd[15:0]}}; end
                    default: begin b.be = 4'b1111; b.wdata = sd; end
                endcase
                busq.push_back(b);
                if (rop) e.data = ext_load(rdat, res[1:0], sz, sg);
                else begin e.rw = 1'b0; e.chk = 1'b0; end
            end
        end
        wbq.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((wbq.size() != 0 || busq.size() != 0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain", wbq.size(), 0);
    endtask

    // Bus responder: checks every REQ cycle against the expected access, then answers.
    initial begin
        int   req_cnt = 0;
        bus_t b;
        forever begin
            @(negedge clk);
            if (rst_n && dmem_req) begin
                if (busq.size() == 0) begin
                    check("unexpected_req", dmem_req, 1'b0);
                end else begin
                    b = busq[0];
                    check("addr", dmem_addr, b.addr);
                    check("be", dmem_be, b.be);
                    check("we", dmem_we, b.we);
                    check("wdata", dmem_wdata, b.wdata);
                    if (req_cnt == b.rdy_d) begin
                        dmem_ready = 1'b1;
                        @(posedge clk);
                        #1 dmem_ready = 1'b0;
                        void'(busq.pop_front());
                        req_cnt = 0;
                        if (b.load) begin
                            repeat (b.rv_d) @(negedge clk);
                            dmem_rdata = b.rdata;
                            dmem_rvalid = 1'b1;
                            @(posedge clk);
                            #1 dmem_rvalid = 1'b0;
                            dmem_rdata = $urandom;
                        end
                    end else begin
                        req_cnt++;
                    end
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // Write-back monitor.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (stall) stall_hi++;
            if (rst_n) begin
                if (wb_valid) begin
                    if (wbq.size() == 0) begin
                        check("unexpected_wb", wb_valid, 1'b0);
                    end else begin
                        e = wbq.pop_front();
                        check("wb_reg_write", wb_reg_write, e.rw);
                        check("misaligned", misaligned, e.mis);
                        check("mem_forward", mem_forward, e.fwd);
                        if (e.chk) begin
                            check("wb_rd", wb_rd, e.rd);
                            check("wb_data", wb_data, e.data);
                        end
                    end
                end else if (misaligned) begin
                    check("stray_misaligned", misaligned, 1'b0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int          s0;
        logic [31:0] res;
        logic [1:0]  sz;
        int          k;

        #2 rst_n = 1'b0;
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_be", dmem_be, 4'b0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_fwd", mem_forward, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        s0 = stall_hi;
        issue(0, 0, 1, 32'd15, 32'h0, 5'd3, 2'b10, 0, 32'h0, 0, 1);
        issue(0, 0, 1, 32'd20, 32'h0, 5'd4, 2'b10, 0, 32'h0, 0, 1);
        issue(0, 0, 1, 32'd25, 32'h0, 5'd5, 2'b10, 0, 32'h0, 0, 1);
        @(negedge clk);
        #1 check("passthru_no_stall", stall_hi, s0);

        issue(0, 1, 0, 32'h100, 32'hDEADBEEF, 5'd1, 2'b10, 0, 32'h0, 2, 1);
        issue(1, 0, 1, 32'h103, 32'h0, 5'd7, 2'b00, 1, 32'h80112233, 0, 1);
        issue(1, 0, 1, 32'h103, 32'h0, 5'd8, 2'b00, 0, 32'h80112233, 1, 2);
        issue(0, 1, 0, 32'h202, 32'h0000BEEF, 5'd9, 2'b01, 0, 32'h0, 0, 1);
        issue(1, 0, 1, 32'h202, 32'h0, 5'd10, 2'b01, 0, 32'h7FFF0000, 0, 1);
        issue(1, 1, 1, 32'h204, 32'h0, 5'd11, 2'b10, 0, 32'hCAFEF00D, 1, 1);
        drain();

        s0 = stall_hi;
        issue(1, 0, 1, 32'h101, 32'h0, 5'd12, 2'b10, 0, 32'h0, 0, 1);
        drain();
        check("misaligned_no_stall", stall_hi, s0);

        for (int i = 0; i < 200; i++) begin
            k   = $urandom_range(0, 3);
            res = $urandom;
            sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) res[0] = 1'b0;
                if (sz == 2'b10) res[1:0] = 2'b00;
            end
            issue(k == 1 || k == 3, k == 2 || k == 3, 1'($urandom), res, $urandom,
                  5'($urandom), sz, 1'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom_range(1, 3));
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        drain();

        issue(1, 0, 1, 32'h300, 32'h0, 5'd13, 2'b10, 1, 32'h12345678, 0, 8);
        repeat (2) @(negedge clk);
        check("wait_stall", stall, 1'b1);
        check("wait_req", dmem_req, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rstw_req", dmem_req, 1'b0);
        check("rstw_stall", stall, 1'b0);
        check("rstw_wb_valid", wb_valid, 1'b0);
        check("rstw_wb_rw", wb_reg_write, 1'b0);
        check("rstw_wb_rd", wb_rd, 5'd0);
        check("rstw_wb_data", wb_data, 32'h0);
        check("rstw_fwd", mem_forward, 32'h0);
        if (wbq.size() != 0) void'(wbq.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_stall", stall, 1'b0);
        check("wbq_empty", wbq.size(), 0);
        check("busq_empty", busq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the execute stage. It captures the EX result, store data and access size/sign, runs a request/response handshake on the data-memory port, and byte-lane aligns and extends load data. It stalls EX while an access is outstanding and hands one completed instruction per pulse to write-back. It also returns its held result to EX as the MEM forwarding source.

## Interface
Parameters:
- WORD_SIZE, 32, datapath width; only 32 supported (4 byte lanes)
- ADDR_SIZE, 32, data-memory address width
- NUM_REGS, 32, architectural registers
- REG_SEL, $clog2(NUM_REGS), register-select width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX presents an instruction this cycle
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- reg_write  in  1  instruction writes rd
- result  in  WORD_SIZE  ALU result / effective address
- save_data  in  WORD_SIZE  store data, right-justified
- rd  in  REG_SEL  destination register
- data_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- data_sign  in  1  1 = sign-extend loads
- stall  out  1  hold EX; in_valid ignored while high
- mem_forward  out  WORD_SIZE  held result, to EX forwarding mux
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_SIZE  word-aligned address
- dmem_wdata  out  WORD_SIZE  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  bus accepts the request this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  WORD_SIZE  read data
- wb_valid  out  1  one-cycle completion pulse
- wb_reg_write  out  1  write-back enable
- wb_rd  out  REG_SEL  write-back register
- wb_data  out  WORD_SIZE  write-back value
- misaligned  out  1  one-cycle fault pulse

## Operation
- FSM states: IDLE, REQ, WAIT. stall = (state != IDLE).
- IDLE with in_valid: the edge latches result, save_data, rd, size, sign, read, write and reg_write into the hold register. mem_forward = held result.
  - Non-memory instruction: on the same edge, wb_valid=1, wb_data=result, wb_rd=rd, wb_reg_write=reg_write. Stays IDLE.
  - Misaligned or illegal access (half with addr[0]=1; word with addr[1:0]!=0; size 11): wb_valid=1, wb_reg_write=0, misaligned=1. No bus request. Stays IDLE.
  - Legal load/store: go to REQ.
- REQ: dmem_req=1. dmem_we=held write. dmem_addr={addr[ADDR_SIZE-1:2],2'b00}. Outputs stay stable until dmem_ready.
  - Byte: be=0001<<addr[1:0], wdata={4{save_data[7:0]}}.
  - Half: be=addr[1]?1100:0011, wdata={2{save_data[15:0]}}.
  - Word: be=1111, wdata=save_data.
  - Edge with dmem_ready: a store completes (wb_valid=1, wb_reg_write=0) and returns to IDLE; a load goes to WAIT.
- WAIT: dmem_req=0. Edge with dmem_rvalid: shift rdata right by 8*addr[1:0], take the low 8/16/32 bits, sign- or zero-extend per data_sign, then write wb_data and set wb_valid=1 and wb_reg_write=reg_write. Return to IDLE. dmem_rvalid outside WAIT is ignored.
- When mem_read and mem_write are both set, the instruction is treated as a load.

## Timing
- Reset (async, immediate): state IDLE. stall, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, mem_forward and misaligned are all 0. Reset during REQ/WAIT drops dmem_req at once, discards the access, and produces no wb pulse.
- Latency from the accept edge to wb_valid:
  - non-memory and misaligned: 1 edge; back-to-back throughput is 1/cycle
  - store: 1 + n edges, where n is the number of REQ cycles (n ≥ 1)
  - load: 1 + n + m edges, where m is the number of WAIT cycles (m ≥ 1)
- wb_valid and misaligned are single-cycle pulses. wb_data, wb_rd and mem_forward hold until the next completion or accept.
- stall rises the cycle after a legal memory op is accepted. It falls in the cycle after the completing edge, so the next instruction can be accepted on the completion cycle + 1.
- Held instruction registers do not change while stall=1.

## Test plan
- ALU passthrough: three consecutive in_valid with result=15, 20, 25 and rd=3, 4, 5 -> three consecutive wb_valid pulses carrying the same values, stall never high.
- Word store: result=0x100, save_data=0xDEADBEEF, size 10, dmem_ready low 2 cycles then high -> dmem_req held 3 cycles with addr 0x100, be 1111, we=1; then wb_valid with wb_reg_write=0.
- Signed byte load: result=0x103, size 00, sign 1, rdata=0x80112233 after 1 WAIT cycle -> wb_data=0xFFFFFF80. The same access with sign 0 -> 0x00000080.
- Half store and load at 0x202: be=1100, wdata=0xBEEFBEEF for save_data 0xBEEF. An unsigned load of rdata 0x7FFF0000 -> wb_data 0x00007FFF.
- Misaligned word at 0x101 -> misaligned pulse, wb_valid with wb_reg_write=0, dmem_req never asserts, stall stays 0.
- rst_n low during WAIT -> dmem_req, stall and all wb outputs are 0 immediately; a later rvalid is ignored and no wb_valid occurs.
